seg_bcd_formatter: RTL and testbench

- Parametrised successor to the ad-hoc divide/modulo display packing in the top level.
- Accepts binary samples from up to 4 producers (I2C ADC reader, SPI slave byte, counters) and converts the selected one to BCD with an iterative double-dabble engine (no dividers).
- Applies leading-zero blanking, over-range indication and a channel tag, then emits a 32-bit packed nibble word for Seg_Display.
- Supports fixed-channel and auto-scan modes, plus display hold.

---
 rtl/seg_bcd_formatter_pkg.sv | 28 ++
 rtl/seg_bcd_formatter_if.sv | 31 +++
 rtl/seg_bcd_formatter_dabble.sv | 61 ++++++
 rtl/seg_bcd_formatter.sv | 198 +++++++++++++++++++
 tb/tb_seg_bcd_formatter.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/seg_bcd_formatter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seg_fmt_pkg
// Brief    : Shared nibble glyph codes, FSM states and helpers for the
//            seven-segment BCD formatter.
// Revision : 1.0 - initial release
// ============================================================================
package seg_fmt_pkg;

    localparam logic [3:0]  SEG_BLANK    = 4'hA;
    localparam logic [3:0]  SEG_DASH     = 4'hB;
    localparam logic [3:0]  SEG_PREFIX   = 4'hF;
    localparam logic [31:0] SEG_RST_WORD = 32'hFAAA_AAAA;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        PACK  = 2'd3
    } fmt_state_t;

    // Double-dabble correction applied to one BCD nibble before each shift.
    function automatic logic [3:0] dabble_adj(input logic [3:0] nib);
        return (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg_bcd_formatter_if.sv
`default_nettype none
// ============================================================================
// Module   : seg_bcd_formatter_if
// Brief    : Sample-producer / display-consumer bundle of the BCD formatter.
// Revision : 1.0 - initial release
// ============================================================================
interface seg_bcd_formatter_if #(
    parameter int DATA_W = 8,
    parameter int CH_NUM = 1
);
    logic [CH_NUM*DATA_W-1:0] in_data;
    logic [CH_NUM-1:0]        in_vld;
    logic                     scan_en;
    logic [1:0]               ch_sel;
    logic                     hold;
    logic [31:0]              dsp_data;
    logic                     dsp_vld;
    logic                     busy;
    logic [1:0]               cur_ch;

    modport master (
        output in_data, in_vld, scan_en, ch_sel, hold,
        input  dsp_data, dsp_vld, busy, cur_ch
    );

    modport slave (
        input  in_data, in_vld, scan_en, ch_sel, hold,
        output dsp_data, dsp_vld, busy, cur_ch
    );
endinterface
`default_nettype wire

// File: rtl/seg_bcd_formatter_dabble.sv
`default_nettype none
// ============================================================================
// Module   : bcd_dabble_iter
// Brief    : Iterative double-dabble binary-to-BCD engine, one bit per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_dabble_iter
    import seg_fmt_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DIGITS = 3
) (
    input  wire logic                sys_clk,
    input  wire logic                sys_rst,
    input  wire logic                i_start,
    input  wire logic [DATA_W-1:0]   i_bin,
    output logic                     o_done,
    output logic [4*DIGITS-1:0]      o_bcd
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] c_last_iter = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);

    logic [BCD_W-1:0]  r_bcd;
    logic [DATA_W-1:0] r_bin;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_run;
    logic [BCD_W-1:0]  w_bcd_adj;

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
        assign w_bcd_adj[4*gi +: 4] = dabble_adj(r_bcd[4*gi +: 4]);
    end

    // Asserted during the cycle that performs the final iteration.
    assign o_done = r_run && (r_cnt == c_last_iter);
    assign o_bcd  = r_bcd;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_bcd <= '0;
            r_bin <= '0;
            r_cnt <= '0;
            r_run <= 1'b0;
        end else if (i_start) begin
            r_bcd <= '0;
            r_bin <= i_bin;
            r_cnt <= '0;
            r_run <= 1'b1;
        end else if (r_run) begin
            {r_bcd, r_bin} <= {w_bcd_adj, r_bin} << 1;
            r_cnt          <= r_cnt + c_cnt_one;
            if (o_done) begin
                r_run <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/seg_bcd_formatter.sv
`default_nettype none
// ============================================================================
// Module   : seg_bcd_formatter
// Brief    : Selects a producer channel, converts its sample to BCD and packs
//            a blanked, tagged 32-bit nibble word for the segment display.
// Revision : 1.0 - initial release
// ============================================================================
module seg_bcd_formatter
    import seg_fmt_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int DIGITS   = 3,
    parameter int CH_NUM   = 1,
    parameter int MAX_DISP = (1 << DATA_W) - 1,
    parameter int SCAN_CYC = 50_000_000
) (
    input  wire logic          sys_clk,
    input  wire logic          sys_rst,
    seg_bcd_formatter_if.slave bus
);

    localparam int BCD_W  = 4 * DIGITS;
    localparam int PAD_W  = 4 * DATA_W;
    localparam int SCAN_W = (SCAN_CYC > 1) ? $clog2(SCAN_CYC) : 1;
    localparam logic [1:0]        c_last_ch   = 2'(CH_NUM - 1);
    localparam logic [SCAN_W-1:0] c_scan_last = SCAN_W'(SCAN_CYC - 1);
    localparam logic [SCAN_W-1:0] c_scan_one  = SCAN_W'(1);
    localparam logic [DATA_W-1:0] c_max_disp  = DATA_W'(MAX_DISP);

    fmt_state_t        r_state;
    fmt_state_t        w_state_nxt;
    logic              w_start;
    logic              w_pack;
    logic              w_done;
    logic [BCD_W-1:0]  w_bcd;

    logic [3:0]        w_vld_pad;
    logic [PAD_W-1:0]  w_data_pad;
    logic [1:0]        w_sel_clamp;
    logic [1:0]        w_act;
    logic              w_act_vld;
    logic [DATA_W-1:0] w_act_data;
    logic              w_switch;
    logic              w_pend_go;

    logic [SCAN_W-1:0] r_scan_cnt;
    logic [1:0]        r_scan_ch;
    logic [1:0]        r_prev_act;
    logic [DATA_W-1:0] r_sample;
    logic [1:0]        r_sample_ch;
    logic              r_pend;
    logic [DATA_W-1:0] r_pend_data;
    logic [1:0]        r_pend_ch;
    logic              r_ovf;

    logic [31:0]       w_word;
    logic              w_lead;
    logic [3:0]        w_nib;
    logic [31:0]       r_dsp_data;
    logic              r_dsp_vld;
    logic [1:0]        r_cur_ch;

    // ---------------- channel selection ----------------
    assign w_vld_pad   = 4'(bus.in_vld);
    assign w_data_pad  = PAD_W'(bus.in_data);
    assign w_sel_clamp = (bus.ch_sel > c_last_ch) ? c_last_ch : bus.ch_sel;
    assign w_act       = bus.scan_en ? r_scan_ch : w_sel_clamp;
    assign w_act_vld   = w_vld_pad[w_act];
    assign w_act_data  = w_data_pad[w_act*DATA_W +: DATA_W];
    assign w_switch    = (w_act != r_prev_act);
    // A pending sample belongs to the previous channel once the selection moves.
    assign w_pend_go   = r_pend && !w_switch;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_scan_cnt <= '0;
            r_scan_ch  <= 2'd0;
        end else if (r_scan_cnt == c_scan_last) begin
            r_scan_cnt <= '0;
            r_scan_ch  <= (r_scan_ch == c_last_ch) ? 2'd0 : r_scan_ch + 2'd1;
        end else begin
            r_scan_cnt <= r_scan_cnt + c_scan_one;
        end
    end

    // ---------------- FSM ----------------
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_pack      = 1'b0;
        case (r_state)
            IDLE:    if (w_act_vld || w_pend_go) w_state_nxt = LOAD;
            LOAD: begin
                w_start     = 1'b1;
                w_state_nxt = SHIFT;
            end
            SHIFT:   if (w_done) w_state_nxt = PACK;
            PACK: begin
                w_pack      = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // ---------------- capture and pending ----------------
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_prev_act  <= 2'd0;
            r_sample    <= '0;
            r_sample_ch <= 2'd0;
            r_pend      <= 1'b0;
            r_pend_data <= '0;
            r_pend_ch   <= 2'd0;
            r_ovf       <= 1'b0;
        end else begin
            r_prev_act <= w_act;
            if (r_state == IDLE && w_act_vld) begin
                r_sample    <= w_act_data;
                r_sample_ch <= w_act;
                r_pend      <= 1'b0;
            end else if (r_state == IDLE && w_pend_go) begin
                r_sample    <= r_pend_data;
                r_sample_ch <= r_pend_ch;
                r_pend      <= 1'b0;
            end else if (r_state != IDLE && w_act_vld) begin
                r_pend_data <= w_act_data;
                r_pend_ch   <= w_act;
                r_pend      <= 1'b1;
            end else if (w_switch) begin
                r_pend <= 1'b0;
            end
            if (r_state == LOAD) begin
                r_ovf <= (r_sample > c_max_disp);
            end
        end
    end

    bcd_dabble_iter #(
        .DATA_W (DATA_W),
        .DIGITS (DIGITS)
    ) u_dabble (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .i_start (w_start),
        .i_bin   (r_sample),
        .o_done  (w_done),
        .o_bcd   (w_bcd)
    );

    // ---------------- blanking and packing ----------------
    always_comb begin
        w_word = {SEG_PREFIX, (CH_NUM > 1) ? {2'b00, r_sample_ch} : SEG_BLANK, 24'hAA_AAAA};
        w_lead = 1'b1;
        w_nib  = 4'd0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            w_nib = w_bcd[4*i +: 4];
            if (r_ovf) begin
                w_word[4*i +: 4] = SEG_DASH;
            end else if (w_lead && (i != 0) && (w_nib == 4'd0)) begin
                w_word[4*i +: 4] = SEG_BLANK;
            end else begin
                w_word[4*i +: 4] = w_nib;
                w_lead           = 1'b0;
            end
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_dsp_data <= SEG_RST_WORD;
            r_dsp_vld  <= 1'b0;
            r_cur_ch   <= 2'd0;
        end else begin
            r_dsp_vld <= 1'b0;
            if (w_pack && !bus.hold) begin
                r_dsp_data <= w_word;
                r_dsp_vld  <= 1'b1;
                r_cur_ch   <= r_sample_ch;
            end
        end
    end

    assign bus.dsp_data = r_dsp_data;
    assign bus.dsp_vld  = r_dsp_vld;
    assign bus.cur_ch   = r_cur_ch;
    assign bus.busy     = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_seg_bcd_formatter.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_bcd_formatter
// Brief    : Scoreboard bench: single-channel and two-channel formatters
//            against a decimal-arithmetic display model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_bcd_formatter;

    localparam int DW   = 8;
    localparam int DG   = 3;
    localparam int SCAN = 40;
    localparam int MAXB = 200;
    localparam int LAT  = DW + 2;

    typedef struct {
        logic [31:0] word;
        logic [1:0]  ch;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc;
    int   n_vec = 0;
    int   n_err = 0;
    int   n_pulse_a = 0;
    int   n_pulse_b = 0;
    exp_t qa[$];
    exp_t qb[$];

    seg_bcd_formatter_if #(.DATA_W(DW), .CH_NUM(1)) ifa ();
    seg_bcd_formatter_if #(.DATA_W(DW), .CH_NUM(2)) ifb ();

    seg_bcd_formatter #(.DATA_W(DW), .DIGITS(DG), .CH_NUM(1), .SCAN_CYC(SCAN)) dut_a (
        .sys_clk (clk),
        .sys_rst (rst),
        .bus     (ifa)
    );

    seg_bcd_formatter #(.DATA_W(DW), .DIGITS(DG), .CH_NUM(2), .MAX_DISP(MAXB), .SCAN_CYC(SCAN)) dut_b (
        .sys_clk (clk),
        .sys_rst (rst),
        .bus     (ifb)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Display word from decimal arithmetic: digit i is shown once v reaches 10^i.
    function automatic logic [31:0] model(input int v, input int ch, input int ch_num, input int max_disp);
        logic [31:0] w;
        int rem;
        w = 32'hFAAA_AAAA;
        if (ch_num > 1) w[27:24] = 4'(ch);
        rem = v;
        for (int i = 0; i < DG; i++) begin
            if (v > max_disp)                 w[4*i +: 4] = 4'hB;
            else if (i == 0 || v >= 10**i)    w[4*i +: 4] = 4'(rem % 10);
            rem = rem / 10;
        end
        return w;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic send_a(input int v, input bit expect_out, input bit timed);
        exp_t e;
        @(negedge clk);
        ifa.in_data = 8'(v);
        ifa.in_vld  = 1'b1;
        if (expect_out) begin
            e.word = model(v, 0, 1, 255);
            e.ch   = 2'd0;
            e.cyc  = timed ? cyc + 1 + LAT : -1;
            qa.push_back(e);
        end
        @(negedge clk);
        ifa.in_vld = 1'b0;
    endtask

    task automatic send_b(input int d0, input int d1, input logic [1:0] vld, input int sel_ch, input bit scan);
        exp_t e;
        int   ch;
        @(negedge clk);
        ch = scan ? (cyc / SCAN) % 2 : sel_ch;
        ifb.in_data = {8'(d1), 8'(d0)};
        ifb.in_vld  = vld;
        if (vld[ch]) begin
            e.word = model((ch == 0) ? d0 : d1, ch, 2, MAXB);
            e.ch   = 2'(ch);
            e.cyc  = cyc + 1 + LAT;
            qb.push_back(e);
        end
        @(negedge clk);
        ifb.in_vld = 2'b00;
    endtask

    task automatic wait_done(input bit which);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (which == 1'b0 && qa.size() == 0 && !ifa.busy) begin ok = 1'b1; break; end
            if (which == 1'b1 && qb.size() == 0 && !ifb.busy) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL timeout_%0d: got no idle within 300 cycles, expected idle", which);
        end
    endtask

    // ---------------- monitors ----------------
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (ifa.dsp_vld === 1'b1) begin
                n_pulse_a++;
                if (qa.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_vld_a: got pulse data %h, expected none", ifa.dsp_data);
                end else begin
                    e = qa.pop_front();
                    check("dsp_data_a", ifa.dsp_data, e.word);
                    check("cur_ch_a", 32'(ifa.cur_ch), 32'(e.ch));
                    if (e.cyc >= 0) check("latency_a", 32'(cyc), 32'(e.cyc));
                end
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (ifb.dsp_vld === 1'b1) begin
                n_pulse_b++;
                if (qb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_vld_b: got pulse data %h, expected none", ifb.dsp_data);
                end else begin
                    e = qb.pop_front();
                    check("dsp_data_b", ifb.dsp_data, e.word);
                    check("cur_ch_b", 32'(ifb.cur_ch), 32'(e.ch));
                    check("latency_b", 32'(cyc), 32'(e.cyc));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish by time limit, expected finish");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        int p;
        int n;
        int v;
        int sel;
        ifa.in_data = '0; ifa.in_vld = '0; ifa.scan_en = 1'b0; ifa.ch_sel = 2'd0; ifa.hold = 1'b0;
        ifb.in_data = '0; ifb.in_vld = '0; ifb.scan_en = 1'b0; ifb.ch_sel = 2'd0; ifb.hold = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_data_a", ifa.dsp_data, 32'hFAAA_AAAA);
        check("rst_vld_a",  32'(ifa.dsp_vld), 32'd0);
        check("rst_busy_a", 32'(ifa.busy), 32'd0);
        check("rst_ch_a",   32'(ifa.cur_ch), 32'd0);
        check("rst_data_b", ifb.dsp_data, 32'hFAAA_AAAA);
        rst = 1'b0;

        // single-channel directed values, including busy duration
        send_a(0, 1, 1);   wait_done(0);
        send_a(7, 1, 1);   wait_done(0);
        send_a(42, 1, 1);
        n = 1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ifa.busy) n++;
            else break;
        end
        check("busy_len_a", 32'(n), 32'(LAT));
        wait_done(0);
        send_a(255, 1, 1); wait_done(0);

        // pending overwrite: 99 replaced by 77
        p = n_pulse_a;
        send_a(12, 1, 1);
        repeat (2) @(negedge clk);
        send_a(99, 0, 0);
        send_a(77, 1, 0);
        wait_done(0);
        check("pend_pulses_a", 32'(n_pulse_a - p), 32'd2);

        // hold keeps the display
        send_a(12, 1, 1); wait_done(0);
        ifa.hold = 1'b1;
        p = n_pulse_a;
        send_a(50, 0, 0); wait_done(0);
        repeat (2) @(negedge clk);
        check("hold_data_a", ifa.dsp_data, 32'hFAAA_AA12);
        check("hold_pulses_a", 32'(n_pulse_a - p), 32'd0);
        ifa.hold = 1'b0;
        send_a(50, 1, 1); wait_done(0);

        repeat (16) begin
            send_a($urandom_range(0, 255), 1, 1);
            wait_done(0);
        end

        // two-channel fixed mode
        ifb.ch_sel = 2'd1;
        send_b(5, 100, 2'b11, 1, 0);  wait_done(1);
        check("fixed_cur_ch_b", 32'(ifb.cur_ch), 32'd1);
        send_b(0, 200, 2'b10, 1, 0);  wait_done(1);
        send_b(0, 201, 2'b10, 1, 0);  wait_done(1);
        send_b(3, 4, 2'b01, 1, 0);    wait_done(1);
        ifb.ch_sel = 2'd0;
        send_b(150, 9, 2'b11, 0, 0);  wait_done(1);
        ifb.ch_sel = 2'd3;
        send_b(1, 9, 2'b11, 1, 0);    wait_done(1);
        repeat (12) begin
            sel = $urandom_range(0, 3);
            ifb.ch_sel = 2'(sel);
            send_b($urandom_range(0, 255), $urandom_range(0, 255), 2'($urandom_range(1, 3)),
                   (sel > 1) ? 1 : sel, 0);
            wait_done(1);
        end

        // reset in the middle of a conversion
        send_a(88, 1, 1);
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        qa.delete();
        check("midrst_data_a", ifa.dsp_data, 32'hFAAA_AAAA);
        check("midrst_busy_a", 32'(ifa.busy), 32'd0);
        check("midrst_data_b", ifb.dsp_data, 32'hFAAA_AAAA);
        check("midrst_ch_b",   32'(ifb.cur_ch), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        p = n_pulse_a;
        repeat (30) @(negedge clk);
        check("post_rst_quiet_a", 32'(n_pulse_a - p), 32'd0);
        send_a(88, 1, 1); wait_done(0);

        // two-channel auto-scan
        ifb.scan_en = 1'b1;
        repeat (14) begin
            repeat ($urandom_range(0, 30)) @(negedge clk);
            v = $urandom_range(0, 255);
            send_b(v, $urandom_range(0, 255), 2'($urandom_range(1, 3)), 0, 1);
            wait_done(1);
        end

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
